if_fetch: RTL

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch -- instruction fetch stage with a 2-entry {inst, pc} buffer.
//
// Issues one word-aligned request at a time to an instruction memory that
// answers (ack + data) in the same cycle it accepts the request. Fetched words
// are queued in a 2-entry FIFO that the decode stage drains; a taken branch
// flushes the FIFO and restarts fetch at the branch target.
//
// Handshakes (valid/ready semantics):
//   imem side   : imem_req_o/imem_addr_o are held stable from assertion until
//                 the cycle imem_ack_i=1; a transfer happens on that cycle only.
//   decode side : valid_o is the valid, ~stall_i is the ready; an entry is
//                 consumed at the rising edge where valid_o=1 and stall_i=0.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   imem_req_o   instruction memory request
//   imem_addr_o  request address (word aligned)
//   imem_ack_i   request accepted, imem_data_i valid this cycle
//   imem_data_i  fetched instruction
//   stall_i      decode stage stall
//   br_taken_i   redirect pulse (highest priority event)
//   br_target_i  redirect address (low two bits ignored)
//   inst_o       instruction to decode (BUBBLE when valid_o=0)
//   pc_o         address of inst_o (0 when valid_o=0)
//   valid_o      inst_o/pc_o hold a real instruction
//   dbg_state_o  current FSM state (RST_WAIT=0, FETCH=1, FULL=2, DRAIN=3)
// ----------------------------------------------------------------------------
module if_fetch #(
    parameter int                  W_INST   = 32,
    parameter int                  W_ADDR   = 32,
    parameter logic [W_ADDR-1:0]   RESET_PC = '0,
    parameter logic [W_INST-1:0]   BUBBLE   = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_o,
    output logic [W_ADDR-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [W_INST-1:0] imem_data_i,
    input  logic              stall_i,
    input  logic              br_taken_i,
    input  logic [W_ADDR-1:0] br_target_i,
    output logic [W_INST-1:0] inst_o,
    output logic [W_ADDR-1:0] pc_o,
    output logic              valid_o,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        FETCH    = 2'd1,
        FULL     = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [W_ADDR-1:0] pc_q, pc_d;
    logic [W_ADDR-1:0] drain_addr_q, drain_addr_d;
    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [W_INST-1:0] fifo_inst_q [2];
    logic [W_ADDR-1:0] fifo_pc_q   [2];

    logic acked;
    logic push;
    logic pop;
    logic clear;

    // ------------------------------------------------------------------
    // Outputs derived from registered state only
    // ------------------------------------------------------------------
    assign imem_req_o  = (state_q == FETCH) || (state_q == DRAIN);
    // Outside DRAIN the PC register is the address; in RST_WAIT/FULL it is
    // shown without a request.
    assign imem_addr_o = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign valid_o     = (count_q != 2'd0);
    assign inst_o      = valid_o ? fifo_inst_q[rd_ptr_q] : BUBBLE;
    assign pc_o        = valid_o ? fifo_pc_q[rd_ptr_q] : '0;
    assign dbg_state_o = state_q;

    assign acked = imem_ack_i & imem_req_o;
    assign pop   = valid_o & ~stall_i;

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        push         = 1'b0;
        clear        = 1'b0;

        if (br_taken_i) begin
            clear = 1'b1;
            pc_d  = {br_target_i[W_ADDR-1:2], 2'b00};
            unique case (state_q)
                RST_WAIT, FULL: state_d = FETCH;
                FETCH: begin
                    // An unacked request must still complete; remember it.
                    if (!acked) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end
                // The old request completing in this same cycle ends the
                // drain; otherwise only the PC is redirected.
                DRAIN: if (acked) state_d = FETCH;
                default: state_d = RST_WAIT;
            endcase
        end else begin
            unique case (state_q)
                RST_WAIT: state_d = FETCH;
                FETCH: begin
                    if (acked) begin
                        push = 1'b1;
                        pc_d = pc_q + W_ADDR'(4);
                        // FIFO fills only when one entry is held and none leaves.
                        if (count_q == 2'd1 && !pop) state_d = FULL;
                    end
                end
                FULL:  if (pop) state_d = FETCH;
                DRAIN: if (acked) state_d = FETCH;
                default: state_d = RST_WAIT;
            endcase
        end

        if (clear) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            rd_ptr_d = rd_ptr_q ^ pop;
            wr_ptr_d = wr_ptr_q ^ push;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RST_WAIT;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            count_q      <= 2'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_inst_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else if (push && !clear) begin
            fifo_inst_q[wr_ptr_q] <= imem_data_i;
            fifo_pc_q[wr_ptr_q]   <= pc_q;
        end
    end

endmodule
